key_edge_pio: RTL and testbench
===============================

// Module: key_edge_pio
// PURPOSE
//  Processor-readable input port for the push-buttons: the read-side counterpart of the LED/HEX output ports.
//  Synchronises and debounces active-low KEY lines, latches press events in a sticky edge-capture register.
//  Avalon-MM slave on the Nios system bus; optional interrupt output.
// PARAMETERS
//  WIDTH            3        number of key inputs (KEY[3:1])
//  DEBOUNCE_CYCLES  500000   consecutive stable cycles before a level is accepted (10 ms at 50 MHz); must be >= 1
//  CNT_W            19       debounce counter width; must satisfy 2**CNT_W >= DEBOUNCE_CYCLES
// PORTS
//  clk_0       in   1      system clock; the only clock
//  reset_n     in   1      synchronous reset, active low
//  in_port     in   WIDTH  raw key pins, asynchronous; 0 = pressed
//  address     in   2      register select
//  read        in   1      read strobe
//  write       in   1      write strobe
//  writedata   in   32     write data
//  readdata    out  32     read data, registered
//  irq         out  1      interrupt request, active high
// BEHAVIOUR
//  Reset (reset_n low at a clk_0 edge): synchroniser and stable level = all 1s (released), counters = 0,
//   edge_capture = 0, irq_mask = 0, readdata = 0, irq = 0. A debounce in progress is discarded.
//  Synchroniser: 2 flops per bit; sync = in_port delayed 2 cycles.
//  Debounce, per bit: if sync == stable -> cnt <= 0; else if cnt == DEBOUNCE_CYCLES-1 -> stable <= sync,
//   cnt <= 0; else cnt <= cnt+1. A change must persist DEBOUNCE_CYCLES consecutive cycles;
//   pin-to-stable latency = 2 + DEBOUNCE_CYCLES cycles. Any reversion restarts the count from 0.
//  Press event: one-cycle pulse press[i] on the cycle stable[i] goes 1 -> 0. Releases do not capture.
//  Register map (address):
//   0 DATA   RO   {zeros, stable}; writes ignored
//   1 MASK   RW   irq_mask[WIDTH-1:0]
//   2 --     RO   reads 0; writes ignored
//   3 EDGE   W1C  edge_capture[WIDTH-1:0]; writing 1 to bit i clears it
//  edge_capture[i] <= (edge_capture[i] & ~clr[i]) | press[i]; a set wins over a clear in the same cycle.
//  Read: readdata <= selected register on the cycle after read is sampled (1-cycle latency, no waitrequest);
//   readdata <= 0 on cycles with read low. Unused upper bits always 0.
//  read and write asserted together: write takes effect; readdata shows pre-write value.
//  irq = |(edge_capture & irq_mask), driven from flops; deasserts the cycle after the clearing write.
// CONFIGURATION
//  KEY_EDGE_PIO_IRQ_EN defined: MASK register implemented, irq as above.
//  Undefined: MASK reads 0, writes ignored, irq tied to 0; edge capture and DATA unchanged.
// STRUCTURE
//  Package key_pio_pkg: ADDR_DATA=2'd0, ADDR_MASK=2'd1, ADDR_EDGE=2'd3, DEBOUNCE_DEFAULT=500000.
//  Sub-module debounce_bit (synchroniser + counter + stable flop + press pulse), one instance per
//   bit via generate; top holds the register file, readdata mux and irq.
// TESTING  (DEBOUNCE_CYCLES=4 for simulation)
//  Reset: reset_n low 1 cycle, in_port=3'b111 -> read addr0 = 0x7, addr3 = 0, irq = 0.
//  Bouncy press: in_port[0] toggles every 2 cycles for 20 cycles then held 0 -> DATA = 0x6 exactly
//   6 cycles after last toggle; EDGE = 0x1; exactly one press pulse.
//  Glitch: in_port[1] low for 3 cycles -> DATA stays 0x7, EDGE stays 0.
//  W1C: EDGE=0x3, write 0x1 to addr3 -> EDGE = 0x2; clear of bit0 coincident with new press -> bit0 stays 1.
//  IRQ (macro on): MASK=0x2; press bit2 -> irq 0; press bit1 -> irq 1; write 0x2 to addr3 -> irq 0 next cycle.
//   Macro off: same sequence -> irq always 0, MASK reads 0.
//  Reset mid-debounce: in_port[2] low 3 cycles, reset_n pulsed, held low -> DATA changes 6 cycles after reset release.

Source files
------------

// File: rtl/key_pio_pkg.sv
// Shared constants for the push-button input port: register addresses and debounce default.
package key_pio_pkg;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd1;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  localparam int DEBOUNCE_DEFAULT = 500000;

  typedef logic [31:0] word_t;

endpackage

// File: rtl/key_edge_pio_debounce_bit.sv
// One key line: two-flop synchroniser, stability counter, accepted level and a press pulse
// on the cycle the accepted level first reads 0.
module debounce_bit
  import key_pio_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int CNT_W           = 19
) (
  input  logic clk_0,
  input  logic reset_n,
  input  logic pin_i,
  output logic stable_o,
  output logic press_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             stable_q, stable_d;
  logic             press_q, press_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d  = pin_i;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    cnt_d    = cnt_q;
    // Any cycle where the synchronised level matches the accepted one restarts the count.
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      stable_d = sync2_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
    press_d = stable_q & ~stable_d;
  end

  always_ff @(posedge clk_0) begin
    if (!reset_n) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      stable_q <= 1'b1;
      press_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      press_q  <= press_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_o = stable_q;
  assign press_o  = press_q;

endmodule

// File: rtl/key_edge_pio.sv
// Debounced push-button input port with sticky W1C press capture on an Avalon-MM slave.
// Define KEY_EDGE_PIO_IRQ_EN to implement the MASK register and the irq output.
module key_edge_pio
  import key_pio_pkg::*;
#(
  parameter int WIDTH           = 3,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int CNT_W           = 19
) (
  input  logic             clk_0,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_port,
  input  logic [1:0]       address,
  input  logic             read,
  input  logic             write,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] press;
  logic [WIDTH-1:0] clr;

  logic [WIDTH-1:0] edge_capture_q, edge_capture_d;
  logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
  word_t            readdata_q, readdata_d;
  logic             irq_q, irq_d;

  logic             unused_wdata;
  assign unused_wdata = ^writedata[31:WIDTH];

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_db (
      .clk_0   (clk_0),
      .reset_n (reset_n),
      .pin_i   (in_port[i]),
      .stable_o(stable[i]),
      .press_o (press[i])
    );
  end

  always_comb begin
    clr = '0;
    if (write && (address == ADDR_EDGE)) begin
      clr = writedata[WIDTH-1:0];
    end
    // A press landing in the same cycle as its clear must not be lost.
    edge_capture_d = (edge_capture_q & ~clr) | press;

`ifdef KEY_EDGE_PIO_IRQ_EN
    irq_mask_d = irq_mask_q;
    if (write && (address == ADDR_MASK)) begin
      irq_mask_d = writedata[WIDTH-1:0];
    end
    irq_d = |(edge_capture_d & irq_mask_d);
`else
    irq_mask_d = '0;
    irq_d      = 1'b0;
`endif

    // Reads use the current register values, so a coincident write is not yet visible.
    readdata_d = '0;
    if (read) begin
      case (address)
        ADDR_DATA: readdata_d[WIDTH-1:0] = stable;
        ADDR_MASK: readdata_d[WIDTH-1:0] = irq_mask_q;
        ADDR_EDGE: readdata_d[WIDTH-1:0] = edge_capture_q;
        default:   readdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk_0) begin
    if (!reset_n) begin
      edge_capture_q <= '0;
      irq_mask_q     <= '0;
      readdata_q     <= '0;
      irq_q          <= 1'b0;
    end else begin
      edge_capture_q <= edge_capture_d;
      irq_mask_q     <= irq_mask_d;
      readdata_q     <= readdata_d;
      irq_q          <= irq_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_key_edge_pio.sv
// Directed bench for key_edge_pio with a short debounce window; honours KEY_EDGE_PIO_IRQ_EN.
module tb_key_edge_pio;

`ifdef KEY_EDGE_PIO_IRQ_EN
  localparam logic [31:0] MASK_RB = 32'h2;
  localparam logic [31:0] IRQ_ON  = 32'h1;
`else
  localparam logic [31:0] MASK_RB = 32'h0;
  localparam logic [31:0] IRQ_ON  = 32'h0;
`endif

  logic        clk_0;
  logic        reset_n;
  logic [2:0]  in_port;
  logic [1:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;
  int n_press0 = 0;

  key_edge_pio #(
    .WIDTH          (3),
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (3)
  ) dut (
    .clk_0    (clk_0),
    .reset_n  (reset_n),
    .in_port  (in_port),
    .address  (address),
    .read     (read),
    .write    (write),
    .writedata(writedata),
    .readdata (readdata),
    .irq      (irq)
  );

  initial clk_0 = 1'b0;
  always #5 clk_0 = ~clk_0;

  always @(posedge clk_0) begin
    if (dut.press[0] === 1'b1) n_press0 <= n_press0 + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic [1:0]  addr;
    logic        rd;
    logic        wr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[15];

  task automatic tick();
    @(posedge clk_0);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic bus(input logic [1:0] a, input logic rd, input logic wr, input logic [31:0] wd);
    address   = a;
    read      = rd;
    write     = wr;
    writedata = wd;
    tick();
    read  = 1'b0;
    write = 1'b0;
  endtask

  task automatic rd_check(input string name, input logic [1:0] a, input logic [31:0] exp);
    bus(a, 1'b1, 1'b0, 32'h0);
    check(name, readdata, exp);
  endtask

  task automatic press_key(input int b);
    in_port[b] = 1'b0;
    repeat (8) tick();
    in_port[b] = 1'b1;
    repeat (8) tick();
  endtask

  initial begin
    int p0_base;

    vecs[0]  = '{2'd0, 1'b1, 1'b0, 32'h0,        32'h7};
    vecs[1]  = '{2'd2, 1'b1, 1'b0, 32'h0,        32'h0};
    vecs[2]  = '{2'd3, 1'b1, 1'b0, 32'h0,        32'h0};
    vecs[3]  = '{2'd1, 1'b1, 1'b0, 32'h0,        32'h0};
    vecs[4]  = '{2'd0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0};
    vecs[5]  = '{2'd0, 1'b1, 1'b0, 32'h0,        32'h7};
    vecs[6]  = '{2'd1, 1'b0, 1'b1, 32'hFFFF_FFF2, 32'h0};
    vecs[7]  = '{2'd1, 1'b1, 1'b0, 32'h0,        MASK_RB};
    vecs[8]  = '{2'd1, 1'b1, 1'b1, 32'h0,        MASK_RB};
    vecs[9]  = '{2'd1, 1'b1, 1'b0, 32'h0,        32'h0};
    vecs[10] = '{2'd2, 1'b0, 1'b1, 32'hFF,       32'h0};
    vecs[11] = '{2'd2, 1'b1, 1'b0, 32'h0,        32'h0};
    vecs[12] = '{2'd3, 1'b0, 1'b1, 32'h7,        32'h0};
    vecs[13] = '{2'd3, 1'b1, 1'b0, 32'h0,        32'h0};
    vecs[14] = '{2'd0, 1'b0, 1'b0, 32'h0,        32'h0};

    reset_n   = 1'b0;
    in_port   = 3'b111;
    address   = 2'd0;
    read      = 1'b0;
    write     = 1'b0;
    writedata = 32'h0;
    tick();
    reset_n = 1'b1;
    check("reset_readdata", readdata, 32'h0);
    check("reset_irq", {31'h0, irq}, 32'h0);

    // Register map after reset
    for (int i = 0; i < 15; i++) begin
      address   = vecs[i].addr;
      read      = vecs[i].rd;
      write     = vecs[i].wr;
      writedata = vecs[i].wdata;
      tick();
      check($sformatf("vec%0d_readdata", i), readdata, vecs[i].exp_rd);
      check($sformatf("vec%0d_irq", i), {31'h0, irq}, 32'h0);
    end
    read  = 1'b0;
    write = 1'b0;

    // Bouncy press on bit 0; readdata trails the accepted level by one cycle
    p0_base = n_press0;
    address = 2'd0;
    read    = 1'b1;
    for (int c = 0; c < 20; c++) begin
      in_port[0] = ((c / 2) % 2 == 1) ? 1'b1 : 1'b0;
      tick();
      check($sformatf("bounce_c%0d", c), readdata, 32'h7);
    end
    in_port[0] = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      check($sformatf("settle_k%0d", k), readdata, (k >= 7) ? 32'h6 : 32'h7);
    end
    read = 1'b0;
    tick();
    check("press_pulse_count", 32'(n_press0 - p0_base), 32'h1);
    rd_check("edge_after_press0", 2'd3, 32'h1);

    in_port[0] = 1'b1;
    repeat (8) tick();
    rd_check("data_after_release", 2'd0, 32'h7);
    rd_check("edge_release_no_capture", 2'd3, 32'h1);
    bus(2'd3, 1'b0, 1'b1, 32'h1);
    rd_check("edge_cleared", 2'd3, 32'h0);

    // Glitch on bit 1 one cycle short of the window
    address    = 2'd0;
    read       = 1'b1;
    in_port[1] = 1'b0;
    for (int c = 0; c < 13; c++) begin
      if (c == 3) in_port[1] = 1'b1;
      tick();
      check($sformatf("glitch_c%0d", c), readdata, 32'h7);
    end
    read = 1'b0;
    rd_check("glitch_edge", 2'd3, 32'h0);

    // W1C, including a clear coincident with a new press
    press_key(0);
    press_key(1);
    rd_check("w1c_edge_both", 2'd3, 32'h3);
    bus(2'd3, 1'b0, 1'b1, 32'h1);
    rd_check("w1c_edge_bit1", 2'd3, 32'h2);
    in_port[0] = 1'b0;
    repeat (6) tick();
    address   = 2'd3;
    read      = 1'b1;
    write     = 1'b1;
    writedata = 32'h1;
    tick();
    read  = 1'b0;
    write = 1'b0;
    check("w1c_coincident_pre", readdata, 32'h2);
    rd_check("w1c_set_wins", 2'd3, 32'h3);
    in_port[0] = 1'b1;
    repeat (8) tick();

    // Interrupt masking and clearing
    bus(2'd3, 1'b0, 1'b1, 32'h7);
    rd_check("irq_edge_clear", 2'd3, 32'h0);
    bus(2'd1, 1'b0, 1'b1, 32'h2);
    rd_check("irq_mask_rb", 2'd1, MASK_RB);
    press_key(2);
    check("irq_masked_press", {31'h0, irq}, 32'h0);
    rd_check("irq_edge_bit2", 2'd3, 32'h4);
    press_key(1);
    check("irq_unmasked_press", {31'h0, irq}, IRQ_ON);
    rd_check("irq_edge_bits21", 2'd3, 32'h6);
    check("irq_before_clear", {31'h0, irq}, IRQ_ON);
    bus(2'd3, 1'b0, 1'b1, 32'h2);
    check("irq_after_clear", {31'h0, irq}, 32'h0);
    rd_check("irq_edge_left", 2'd3, 32'h4);

    // Reset in the middle of a debounce on bit 2
    in_port[2] = 1'b0;
    repeat (3) tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("midreset_readdata", readdata, 32'h0);
    check("midreset_irq", {31'h0, irq}, 32'h0);
    address = 2'd0;
    read    = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      check($sformatf("midreset_k%0d", k), readdata, (k >= 7) ? 32'h3 : 32'h7);
    end
    read = 1'b0;
    repeat (2) tick();
    rd_check("midreset_edge", 2'd3, 32'h4);
    rd_check("midreset_mask", 2'd1, 32'h0);
    in_port[2] = 1'b1;
    repeat (8) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
